periph_bridge: RTL and testbench
================================

Name: periph_bridge

Overview:
- Parametrised successor to the single-peripheral data-bus splitter that sits between the CPU data port, dmem and the peripherals.
- Decodes the CPU data address into dmem or one of NUM_PERIPH peripheral slots. Dmem traffic passes straight through.
- Each peripheral access runs through a registered SETUP/ACCESS handshake with per-slot ready, and the CPU is held off with a stall signal until the access completes.
- Out-of-range slots are flagged; timed-out slots are flagged when PERIPH_BRIDGE_TIMEOUT_EN is defined.

Parameters:
- NUM_PERIPH, 4: number of peripheral slots, 1..16.
- PERIPH_BASE, 32'h0000_1000: base of the peripheral window.
- WIN_SHIFT, 12: the window matches when daddr[31:WIN_SHIFT] == PERIPH_BASE[31:WIN_SHIFT].
- SLOT_LSB, 8: slot index = daddr[SLOT_LSB+3:SLOT_LSB], a 4-bit field.
- REG_AW, 4: register offset width; offset = daddr[REG_AW+1:2].
- TIMEOUT, 16: ACCESS cycles allowed before abort; only used with PERIPH_BRIDGE_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- daddr  in  32  CPU data address.
- dwdata  in  32  CPU write data.
- we  in  4  CPU byte write enables.
- re  in  1  CPU read strobe.
- drdata  out  32  read data returned to the CPU.
- stall  out  1  holds the CPU while a peripheral access is in progress.
- dmem_we  out  4  gated byte write enables to dmem.
- dmem_rdata  in  32  read data from dmem.
- p_sel  out  NUM_PERIPH  one-hot peripheral select.
- p_en  out  1  access phase strobe.
- p_we  out  1  write access.
- p_strb  out  4  byte strobes.
- p_addr  out  REG_AW  register offset.
- p_wdata  out  32  write data to the peripheral.
- p_rdata  in  NUM_PERIPH*32  read data; slot k occupies bits [32k+31:32k].
- p_ready  in  NUM_PERIPH  per-slot ready.
- err_flag  out  1  sticky error flag.
- err_slot  out  4  slot index of the first error.
- err_clr  in  1  synchronous clear of err_flag and err_slot.

Behaviour:
- Request definition: req = in_window & (re | (|we)).
- Dmem path (not in_window):
  - dmem_we = we; drdata = dmem_rdata; stall = 0; no peripheral activity.
- Peripheral path (in_window):
  - dmem_we = 0.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - stall = req, combinationally.
  - On req, latch slot, offset, dwdata, we and a write flag (|we).
  - If slot < NUM_PERIPH, go to SETUP. Otherwise set the error and go to DONE with rdata_q = 0.
- SETUP:
  - p_sel[slot] = 1, p_en = 0, stall = 1.
  - Always go to ACCESS.
- ACCESS:
  - p_sel[slot] = 1, p_en = 1, stall = 1.
  - When p_ready[slot] = 1, capture p_rdata for that slot into rdata_q and go to DONE.
- DONE:
  - stall = 0, drdata = rdata_q. The CPU samples the result on this cycle.
  - Always go to IDLE. The request still present in DONE must not retrigger.
- Latency: a zero-wait peripheral stalls the CPU for 3 cycles (IDLE, SETUP, ACCESS). Each cycle of p_ready low adds one cycle.
- Peripheral outputs:
  - p_we, p_strb, p_addr and p_wdata come from the latched copies. They are stable from SETUP through ACCESS.
  - p_sel and p_en are 0 in IDLE and DONE.
  - On writes, rdata_q is 0.
- Error flag:
  - Setting err_flag records err_slot, but only if err_flag was 0; the first error wins.
  - err_clr clears both. A set and a clear in the same cycle: set wins.
- Reset values, all asynchronous on reset_n low: state IDLE; rdata_q 0; latched copies 0; err_flag 0; err_slot 0.
- Reset mid-access: p_sel and p_en drop immediately. stall follows req and the IDLE rules afterwards. No write is replayed.
- p_ready on a non-selected slot is ignored.
- Word-aligned accesses only; daddr[1:0] is ignored.

Optional Feature:
- Macro: PERIPH_BRIDGE_TIMEOUT_EN.
- When defined:
  - An 8-bit wait counter is cleared on entry to ACCESS and incremented each ACCESS cycle with p_ready low.
  - When the count reaches TIMEOUT-1 with p_ready still low, the bridge sets the error (err_slot = slot), loads rdata_q = 32'hDEAD_BEEF and goes to DONE.
- When undefined: no counter exists, and ACCESS waits for p_ready indefinitely.

Decomposition:
- Package periph_bridge_pkg contains:
  - the state enum (IDLE, SETUP, ACCESS, DONE);
  - localparam TIMEOUT_DATA = 32'hDEAD_BEEF;
  - localparam SLOT_FW = 4.
- Sub-module periph_addr_dec is combinational. It takes daddr and the window/slot parameters and produces in_window, slot, offset and slot_valid.
- The FSM, the datapath registers and the rdata/ready mux stay in periph_bridge.

Test Plan:
- Dmem pass-through: daddr = 0x40, we = 4'hF, dwdata = 0x12345678 -> dmem_we = 4'hF, stall = 0, p_sel = 0. A read at 0x40 gives drdata = dmem_rdata in the same cycle.
- Zero-wait write: daddr = 0x1204, we = 4'h3, dwdata = 0xA5A5, p_ready = 4'hF -> stall high for 3 cycles; p_sel = 4'b0100 in SETUP/ACCESS; p_addr = 1; p_strb = 4'h3; p_en only in ACCESS; DONE in cycle 4.
- Wait-state read: daddr = 0x1108, re = 1, p_ready[1] low for 5 ACCESS cycles, p_rdata slot 1 = 0xCAFEF00D -> stall lasts 8 cycles, then drdata = 0xCAFEF00D in DONE.
- Invalid slot: daddr = 0x1F00 with NUM_PERIPH = 4 -> no p_sel; stall for 1 cycle; drdata = 0; err_flag = 1; err_slot = 15. A second error leaves err_slot = 15. err_clr clears both.
- Timeout, with the macro defined and TIMEOUT = 16: a read to slot 2 with p_ready[2] stuck low -> 16 ACCESS cycles, then drdata = 0xDEADBEEF, err_flag = 1, err_slot = 2.
- Reset mid-ACCESS: assert reset_n = 0 during a slot-3 wait -> p_sel = 0, p_en = 0 and err_flag = 0 asynchronously. After release, a fresh dmem access proceeds with stall = 0.

Source files
------------

// File: rtl/periph_bridge_pkg.sv
// ============================================================================
// periph_bridge_pkg : shared types and constants for the peripheral bridge
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package periph_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
  localparam int          SLOT_FW      = 4;

endpackage

`default_nettype wire

// File: rtl/periph_bridge_if.sv
// ============================================================================
// periph_bridge_if : CPU data port, dmem and peripheral bus bundle
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface periph_bridge_if #(
  parameter int NUM_PERIPH = 4,
  parameter int REG_AW     = 4
);
  logic [31:0]              daddr;
  logic [31:0]              dwdata;
  logic [3:0]               we;
  logic                     re;
  logic [31:0]              drdata;
  logic                     stall;
  logic [3:0]               dmem_we;
  logic [31:0]              dmem_rdata;
  logic [NUM_PERIPH-1:0]    p_sel;
  logic                     p_en;
  logic                     p_we;
  logic [3:0]               p_strb;
  logic [REG_AW-1:0]        p_addr;
  logic [31:0]              p_wdata;
  logic [NUM_PERIPH*32-1:0] p_rdata;
  logic [NUM_PERIPH-1:0]    p_ready;
  logic                     err_flag;
  logic [3:0]               err_slot;
  logic                     err_clr;

  modport slave (
    input  daddr, dwdata, we, re, dmem_rdata, p_rdata, p_ready, err_clr,
    output drdata, stall, dmem_we, p_sel, p_en, p_we, p_strb, p_addr, p_wdata,
           err_flag, err_slot
  );

  modport master (
    output daddr, dwdata, we, re, dmem_rdata, p_rdata, p_ready, err_clr,
    input  drdata, stall, dmem_we, p_sel, p_en, p_we, p_strb, p_addr, p_wdata,
           err_flag, err_slot
  );

endinterface

`default_nettype wire

// File: rtl/periph_addr_dec.sv
// ============================================================================
// periph_addr_dec : splits a CPU data address into window hit, slot, offset
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module periph_addr_dec
  import periph_bridge_pkg::*;
#(
  parameter logic [31:0] PERIPH_BASE = 32'h0000_1000,
  parameter int          WIN_SHIFT   = 12,
  parameter int          SLOT_LSB    = 8,
  parameter int          NUM_PERIPH  = 4,
  parameter int          REG_AW      = 4
) (
  input  logic [31:0]        daddr_i,
  output logic               in_window_o,
  output logic [SLOT_FW-1:0] slot_o,
  output logic [REG_AW-1:0]  offset_o,
  output logic               slot_valid_o
);

  // Only the decoded fields matter; the rest of the address is don't-care.
  logic unused_addr;
  assign unused_addr = ^daddr_i;

  assign in_window_o  = (daddr_i[31:WIN_SHIFT] == PERIPH_BASE[31:WIN_SHIFT]);
  assign slot_o       = daddr_i[SLOT_LSB+SLOT_FW-1:SLOT_LSB];
  assign offset_o     = daddr_i[REG_AW+1:2];
  assign slot_valid_o = ({1'b0, slot_o} < 5'(NUM_PERIPH));

endmodule

`default_nettype wire

// File: rtl/periph_bridge.sv
// ============================================================================
// periph_bridge : CPU data bus splitter, dmem pass-through plus N peripheral
//                 slots with SETUP/ACCESS handshake. Optional PERIPH_BRIDGE_TIMEOUT_EN.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module periph_bridge
  import periph_bridge_pkg::*;
#(
  parameter int          NUM_PERIPH  = 4,
  parameter logic [31:0] PERIPH_BASE = 32'h0000_1000,
  parameter int          WIN_SHIFT   = 12,
  parameter int          SLOT_LSB    = 8,
  parameter int          REG_AW      = 4,
  parameter int          TIMEOUT     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  periph_bridge_if.slave   bus
);

  state_e                state_q, state_d;
  logic [SLOT_FW-1:0]    slot_q, slot_d;
  logic [REG_AW-1:0]     off_q, off_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            strb_q, strb_d;
  logic                  wr_q, wr_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_flag_q, err_flag_d;
  logic [SLOT_FW-1:0]    err_slot_q, err_slot_d;
  logic                  err_set;
  logic [SLOT_FW-1:0]    err_set_slot;

  logic                  in_window, dec_valid, req, active;
  logic [SLOT_FW-1:0]    dec_slot;
  logic [REG_AW-1:0]     dec_off;
  logic [31:0]           sel_rdata;
  logic                  sel_ready;

`ifdef PERIPH_BRIDGE_TIMEOUT_EN
  logic [7:0]            cnt_q, cnt_d;
`else
  logic [7:0]            unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
`endif

  periph_addr_dec #(
    .PERIPH_BASE (PERIPH_BASE),
    .WIN_SHIFT   (WIN_SHIFT),
    .SLOT_LSB    (SLOT_LSB),
    .NUM_PERIPH  (NUM_PERIPH),
    .REG_AW      (REG_AW)
  ) u_dec (
    .daddr_i      (bus.daddr),
    .in_window_o  (in_window),
    .slot_o       (dec_slot),
    .offset_o     (dec_off),
    .slot_valid_o (dec_valid)
  );

  assign req    = in_window & (bus.re | (|bus.we));
  assign active = (state_q == SETUP) || (state_q == ACCESS);

  // Only the latched slot's data and ready are visible to the FSM.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    for (int k = 0; k < NUM_PERIPH; k++) begin
      if (slot_q == SLOT_FW'(k)) begin
        sel_rdata = bus.p_rdata[k*32 +: 32];
        sel_ready = bus.p_ready[k];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;
    wr_d         = wr_q;
    rdata_d      = rdata_q;
    err_set      = 1'b0;
    err_set_slot = slot_q;
`ifdef PERIPH_BRIDGE_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          slot_d  = dec_slot;
          off_d   = dec_off;
          wdata_d = bus.dwdata;
          strb_d  = bus.we;
          wr_d    = |bus.we;
          if (dec_valid) begin
            state_d = SETUP;
          end else begin
            err_set      = 1'b1;
            err_set_slot = dec_slot;
            rdata_d      = '0;
            state_d      = DONE;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef PERIPH_BRIDGE_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ACCESS: begin
        if (sel_ready) begin
          rdata_d = wr_q ? '0 : sel_rdata;
          state_d = DONE;
        end
`ifdef PERIPH_BRIDGE_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT - 1)) begin
          err_set = 1'b1;
          rdata_d = TIMEOUT_DATA;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // First error wins; a simultaneous set overrides the clear.
  always_comb begin
    err_flag_d = err_flag_q;
    err_slot_d = err_slot_q;
    if (err_set) begin
      if (!err_flag_q) err_slot_d = err_set_slot;
      err_flag_d = 1'b1;
    end else if (bus.err_clr) begin
      err_flag_d = 1'b0;
      err_slot_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      off_q      <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      wr_q       <= 1'b0;
      rdata_q    <= '0;
      err_flag_q <= 1'b0;
      err_slot_q <= '0;
`ifdef PERIPH_BRIDGE_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      off_q      <= off_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      wr_q       <= wr_d;
      rdata_q    <= rdata_d;
      err_flag_q <= err_flag_d;
      err_slot_q <= err_slot_d;
`ifdef PERIPH_BRIDGE_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign bus.stall    = active | ((state_q == IDLE) & req);
  assign bus.dmem_we  = in_window ? 4'h0 : bus.we;
  assign bus.drdata   = (in_window || (state_q != IDLE)) ? rdata_q : bus.dmem_rdata;
  assign bus.p_sel    = active ? (NUM_PERIPH'(1) << slot_q) : '0;
  assign bus.p_en     = (state_q == ACCESS);
  assign bus.p_we     = wr_q;
  assign bus.p_strb   = strb_q;
  assign bus.p_addr   = off_q;
  assign bus.p_wdata  = wdata_q;
  assign bus.err_flag = err_flag_q;
  assign bus.err_slot = err_slot_q;

endmodule

`default_nettype wire

// File: tb/tb_periph_bridge.sv
// ============================================================================
// tb_periph_bridge : transaction-level model of the bridge, per-cycle compare
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_periph_bridge;

  localparam int          NP       = 4;
  localparam int          TO       = 16;
  localparam logic [31:0] DMEM_VAL = 32'h0BAD_C0DE;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  periph_bridge_if #(.NUM_PERIPH(NP), .REG_AW(4)) bus ();

  periph_bridge #(
    .NUM_PERIPH  (NP),
    .PERIPH_BASE (32'h0000_1000),
    .WIN_SHIFT   (12),
    .SLOT_LSB    (8),
    .REG_AW      (4),
    .TIMEOUT     (TO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic          stall;
    logic [NP-1:0] p_sel;
    logic          p_en;
    logic          p_we;
    logic [3:0]    p_strb;
    logic [3:0]    p_addr;
    logic [31:0]   p_wdata;
    logic [3:0]    dmem_we;
    logic          chk_rd;
    logic [31:0]   drdata;
    logic          err_flag;
    logic [3:0]    err_slot;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_cur;
  bit          exp_valid = 1'b0;
  logic        m_flag;
  logic [3:0]  m_slot;
  int          stall_run = 0;
  int          last_len = 0;
  logic [31:0] last_drdata = '0;

  function automatic logic [31:0] slot_data(input logic [3:0] k);
    case (k)
      4'd0:    return 32'h1111_0000;
      4'd1:    return 32'hCAFE_F00D;
      4'd2:    return 32'h2222_0002;
      default: return 32'h3333_0003;
    endcase
  endfunction

  function automatic exp_t blank();
    exp_t e;
    e.stall = 1'b0; e.p_sel = '0; e.p_en = 1'b0; e.p_we = 1'b0;
    e.p_strb = '0; e.p_addr = '0; e.p_wdata = '0; e.dmem_we = '0;
    e.chk_rd = 1'b0; e.drdata = '0; e.err_flag = 1'b0; e.err_slot = '0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      chk("stall",    32'(bus.stall),    32'(exp_cur.stall));
      chk("p_sel",    32'(bus.p_sel),    32'(exp_cur.p_sel));
      chk("p_en",     32'(bus.p_en),     32'(exp_cur.p_en));
      chk("dmem_we",  32'(bus.dmem_we),  32'(exp_cur.dmem_we));
      chk("err_flag", 32'(bus.err_flag), 32'(exp_cur.err_flag));
      chk("err_slot", 32'(bus.err_slot), 32'(exp_cur.err_slot));
      if (exp_cur.p_sel != '0) begin
        chk("p_we",    32'(bus.p_we),   32'(exp_cur.p_we));
        chk("p_strb",  32'(bus.p_strb), 32'(exp_cur.p_strb));
        chk("p_addr",  32'(bus.p_addr), 32'(exp_cur.p_addr));
        chk("p_wdata", bus.p_wdata,     exp_cur.p_wdata);
      end
      if (exp_cur.chk_rd) chk("drdata", bus.drdata, exp_cur.drdata);
      if (bus.stall) begin
        stall_run++;
      end else if (stall_run != 0) begin
        last_len    = stall_run;
        last_drdata = bus.drdata;
        stall_run   = 0;
      end
    end
  end

  // One CPU cycle: drive inputs, publish expectation, advance the error model.
  task automatic step(input logic [31:0] a, input logic [3:0] w, input logic [31:0] wd,
                      input logic r, input logic [NP-1:0] rdy, input logic clr,
                      input exp_t e, input logic set_err, input logic [3:0] set_slot);
    @(posedge clk); #1;
    bus.daddr = a; bus.we = w; bus.dwdata = wd; bus.re = r;
    bus.p_ready = rdy; bus.err_clr = clr;
    e.err_flag = m_flag;
    e.err_slot = m_slot;
    exp_cur   = e;
    exp_valid = 1'b1;
    if (set_err) begin
      if (!m_flag) m_slot = set_slot;
      m_flag = 1'b1;
    end else if (clr) begin
      m_flag = 1'b0;
      m_slot = 4'd0;
    end
  endtask

  // Whole CPU access; waits = ready-low ACCESS cycles; clr applies to first cycle.
  task automatic run_txn(input logic [31:0] a, input logic [3:0] w, input logic [31:0] wd,
                         input logic r, input int waits, input logic clr, input int max_cyc);
    exp_t          e;
    logic [3:0]    s, off;
    logic [NP-1:0] oh, ones;
    int            n_acc, cyc;
    bit            tout;
    ones = '1;
    s    = a[11:8];
    off  = a[5:2];
    cyc  = 0;
    if (a[31:12] != 20'h00001) begin
      e = blank(); e.dmem_we = w; e.chk_rd = 1'b1; e.drdata = DMEM_VAL;
      step(a, w, wd, r, ones, clr, e, 1'b0, 4'd0);
      return;
    end
    if (32'(s) >= NP) begin
      e = blank(); e.stall = 1'b1;
      step(a, w, wd, r, ones, clr, e, 1'b1, s);
      e = blank(); e.chk_rd = 1'b1; e.drdata = 32'h0;
      step(a, w, wd, r, ones, 1'b0, e, 1'b0, 4'd0);
      return;
    end
    oh = NP'(1) << s;
    e = blank(); e.stall = 1'b1;
    step(a, w, wd, r, ones, clr, e, 1'b0, 4'd0);
    cyc++; if (cyc >= max_cyc) return;
    e.p_sel = oh; e.p_we = |w; e.p_strb = w; e.p_addr = off; e.p_wdata = wd;
    step(a, w, wd, r, ones, 1'b0, e, 1'b0, 4'd0);
    cyc++; if (cyc >= max_cyc) return;
    n_acc = waits + 1;
    tout  = 1'b0;
`ifdef PERIPH_BRIDGE_TIMEOUT_EN
    if (n_acc > TO) begin
      n_acc = TO;
      tout  = 1'b1;
    end
`endif
    e.p_en = 1'b1;
    for (int i = 0; i < n_acc; i++) begin
      step(a, w, wd, r, (i < waits) ? ~oh : ones, 1'b0, e, tout && (i == n_acc - 1), s);
      cyc++; if (cyc >= max_cyc) return;
    end
    e = blank(); e.chk_rd = 1'b1;
    e.drdata = tout ? 32'hDEAD_BEEF : ((w != 4'h0) ? 32'h0 : slot_data(s));
    step(a, w, wd, r, ones, 1'b0, e, 1'b0, 4'd0);
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    bus.daddr      = 32'h0000_1000;
    bus.dwdata     = '0;
    bus.we         = '0;
    bus.re         = 1'b0;
    bus.err_clr    = 1'b0;
    bus.p_ready    = '1;
    bus.p_rdata    = {slot_data(4'd3), slot_data(4'd2), slot_data(4'd1), slot_data(4'd0)};
    bus.dmem_rdata = DMEM_VAL;
    m_flag         = 1'b0;
    m_slot         = 4'd0;

    #2;
    chk("rst_stall",  32'(bus.stall),    32'd0);
    chk("rst_psel",   32'(bus.p_sel),    32'd0);
    chk("rst_pen",    32'(bus.p_en),     32'd0);
    chk("rst_flag",   32'(bus.err_flag), 32'd0);
    chk("rst_slot",   32'(bus.err_slot), 32'd0);
    chk("rst_rdata",  bus.drdata,        32'd0);
    bus.daddr = 32'h0000_0000;
    #1;
    chk("rst_dmem_rd", bus.drdata, DMEM_VAL);
    #9 reset_n = 1'b1;

    // dmem pass-through write then read
    run_txn(32'h0000_0040, 4'hF, 32'h1234_5678, 1'b0, 0, 1'b0, 99);
    run_txn(32'h0000_0040, 4'h0, 32'h0,         1'b1, 0, 1'b0, 99);

    // zero-wait write to slot 2, offset 1
    run_txn(32'h0000_1204, 4'h3, 32'h0000_A5A5, 1'b0, 0, 1'b0, 99);
    settle();
    chk("wr_lat", 32'(last_len), 32'd3);

    // wait-state read from slot 1
    run_txn(32'h0000_1108, 4'h0, 32'h0, 1'b1, 5, 1'b0, 99);
    settle();
    chk("rd_lat",  32'(last_len), 32'd8);
    chk("rd_data", last_drdata,   32'hCAFE_F00D);

    // back-to-back: read slot 0, write slot 3 with waits
    run_txn(32'h0000_1000, 4'h0, 32'h0,         1'b1, 0, 1'b0, 99);
    run_txn(32'h0000_130C, 4'hF, 32'h5A5A_0F0F, 1'b0, 2, 1'b0, 99);

    // out-of-range slots: first error wins
    run_txn(32'h0000_1F00, 4'h0, 32'h0, 1'b1, 0, 1'b0, 99);
    settle();
    chk("inv_lat",  32'(last_len),     32'd1);
    chk("inv_data", last_drdata,       32'h0);
    chk("inv_flag", 32'(bus.err_flag), 32'd1);
    chk("inv_slot", 32'(bus.err_slot), 32'd15);
    run_txn(32'h0000_1E00, 4'h1, 32'h1, 1'b0, 0, 1'b0, 99);
    settle();
    chk("inv2_slot", 32'(bus.err_slot), 32'd15);

    // clear, then set and clear together
    run_txn(32'h0000_0080, 4'h0, 32'h0, 1'b0, 0, 1'b1, 99);
    run_txn(32'h0000_0080, 4'h0, 32'h0, 1'b0, 0, 1'b0, 99);
    settle();
    chk("clr_flag", 32'(bus.err_flag), 32'd0);
    chk("clr_slot", 32'(bus.err_slot), 32'd0);
    run_txn(32'h0000_1D00, 4'h0, 32'h0, 1'b1, 0, 1'b1, 99);
    settle();
    chk("setclr_flag", 32'(bus.err_flag), 32'd1);
    chk("setclr_slot", 32'(bus.err_slot), 32'd13);

`ifdef PERIPH_BRIDGE_TIMEOUT_EN
    run_txn(32'h0000_0080, 4'h0, 32'h0, 1'b0, 0, 1'b1, 99);
    run_txn(32'h0000_1200, 4'h0, 32'h0, 1'b1, 100, 1'b0, 999);
    settle();
    chk("to_lat",  32'(last_len),     32'd18);
    chk("to_data", last_drdata,       32'hDEAD_BEEF);
    chk("to_slot", 32'(bus.err_slot), 32'd2);
`else
    run_txn(32'h0000_1200, 4'h0, 32'h0, 1'b1, 20, 1'b0, 999);
    settle();
    chk("long_lat",  32'(last_len), 32'd23);
    chk("long_data", last_drdata,   32'h2222_0002);
`endif

    // reset in the middle of a slot-3 wait
    run_txn(32'h0000_1300, 4'h0, 32'h0, 1'b1, 50, 1'b0, 4);
    settle();
    chk("pre_rst_flag", 32'(bus.err_flag), 32'd1);
    exp_valid = 1'b0;
    reset_n   = 1'b0;
    #1;
    chk("mid_rst_psel",  32'(bus.p_sel),    32'd0);
    chk("mid_rst_pen",   32'(bus.p_en),     32'd0);
    chk("mid_rst_flag",  32'(bus.err_flag), 32'd0);
    chk("mid_rst_stall", 32'(bus.stall),    32'd1);
    m_flag    = 1'b0;
    m_slot    = 4'd0;
    stall_run = 0;
    #10;
    bus.daddr = 32'h0000_0044;
    bus.re    = 1'b0;
    #1;
    chk("rst_norq_stall", 32'(bus.stall), 32'd0);
    reset_n = 1'b1;

    run_txn(32'h0000_0044, 4'h5, 32'h0000_00AA, 1'b0, 0, 1'b0, 99);
    run_txn(32'h0000_1300, 4'h0, 32'h0,         1'b1, 0, 1'b0, 99);
    settle();
    chk("post_rst_data", last_drdata, 32'h3333_0003);

    exp_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
